uart_tx_fifo: RTL and testbench

- Parametrised successor to the fixed 8N1 UART transmitter in the host-interface path of the PUF interface.
- Adds a configurable data width, an exact configurable oversample ratio, and runtime parity and stop-bit modes.
- Adds a break generator and an internal FIFO with a valid/ready write port, so the PUF response serialiser can push words back-to-back without polling for done.

---
 rtl/uart_tx_fifo.sv | 128 ++++++++++++
 tb/tb_uart_tx_fifo.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: parametrised UART transmitter with valid/ready write FIFO, parity, stop-bit and break control
//   sys_clk, sys_rst          clock, synchronous active-high reset
//   xmit_validH/dataH/readyH  FIFO write port, push when valid and ready
//   parity_modeH, two_stopH   frame format, latched when a word is loaded
//   break_reqH                hold the line low while idle
//   uart_xmitH                registered serial line
//   xmit_doneH                idle, FIFO empty and no break
//   frame_doneH               one-cycle pulse at the end of each frame
//   fifo_countH               FIFO occupancy
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 xmit_validH,
    input  logic [DATA_BITS-1:0] xmit_dataH,
    output logic                 xmit_readyH,
    input  logic [1:0]           parity_modeH,
    input  logic                 two_stopH,
    input  logic                 break_reqH,
    output logic                 uart_xmitH,
    output logic                 xmit_doneH,
    output logic                 frame_doneH,
    output logic [CNT_W-1:0]     fifo_countH
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] CELL_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state, stateNext;
    logic [DATA_BITS-1:0] fifoMem [FIFO_DEPTH];
    logic [AW-1:0]        wrPtr, rdPtr;
    logic [DATA_BITS-1:0] shiftReg, headWord;
    logic [CW-1:0]        cellCnt;
    logic [3:0]           bitCnt;
    logic                 parityBit, parityEn, twoStop;
    logic                 push, pop, cellEnd, frameEnd, lineNext;
    logic [CNT_W-1:0]     countNext;

    assign xmit_readyH = fifo_countH != FULL;
    assign push        = xmit_validH && xmit_readyH;
    assign headWord    = fifoMem[rdPtr];
    assign cellEnd     = cellCnt == CELL_LAST;

    // The line register follows the current state, so the line lags the
    // state by one cycle; every cell still lasts exactly OVERSAMPLE cycles.
    always_comb begin
        stateNext = IDLE;
        pop       = 1'b0;
        frameEnd  = 1'b0;
        lineNext  = 1'b1;
        case (state)
            IDLE: begin
                lineNext  = !break_reqH;
                pop       = fifo_countH != '0 && !break_reqH;
                stateNext = pop ? START : IDLE;
            end
            START: begin
                lineNext  = 1'b0;
                stateNext = cellEnd ? DATA : START;
            end
            DATA: begin
                lineNext  = shiftReg[0];
                stateNext = !(cellEnd && bitCnt == DATA_LAST) ? DATA : parityEn ? PARITY : STOP;
            end
            PARITY: begin
                lineNext  = parityBit;
                stateNext = cellEnd ? STOP : PARITY;
            end
            STOP: begin
                // bitCnt counts stop cells here: the frame ends after cell 0 or cell 1
                frameEnd  = cellEnd && bitCnt == 4'(twoStop);
                pop       = frameEnd && fifo_countH != '0;
                stateNext = !frameEnd ? STOP : pop ? START : IDLE;
            end
            default: ;
        endcase
        countNext = fifo_countH + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state       <= IDLE;
            wrPtr       <= '0;
            rdPtr       <= '0;
            fifo_countH <= '0;
            shiftReg    <= '0;
            cellCnt     <= '0;
            bitCnt      <= '0;
            parityBit   <= 1'b0;
            parityEn    <= 1'b0;
            twoStop     <= 1'b0;
            uart_xmitH  <= 1'b1;
            xmit_doneH  <= 1'b1;
            frame_doneH <= 1'b0;
        end else begin
            state       <= stateNext;
            fifo_countH <= countNext;
            if (push)
                wrPtr <= wrPtr + AW'(1);
            if (pop) begin
                rdPtr     <= rdPtr + AW'(1);
                shiftReg  <= headWord;
                parityEn  <= parity_modeH == 2'b01 || parity_modeH == 2'b10;
                parityBit <= parity_modeH == 2'b01 ? ~^headWord : ^headWord;
                twoStop   <= two_stopH;
            end else if (state == DATA && cellEnd)
                shiftReg <= shiftReg >> 1;
            cellCnt     <= (stateNext != state || cellEnd) ? '0 : cellCnt + CW'(1);
            bitCnt      <= (stateNext != state) ? '0 : bitCnt + 4'(cellEnd);
            uart_xmitH  <= lineNext;
            xmit_doneH  <= stateNext == IDLE && countNext == '0 && !break_reqH;
            frame_doneH <= frameEnd;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (push && !sys_rst)
            fifoMem[wrPtr] <= xmit_dataH;
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed scoreboard bench for uart_tx_fifo in three width/ratio configurations
module tb_uart_tx_fifo;
    typedef struct {
        logic [15:0] bits;
        int          cells;
        int          os;
        bit          b2b;
    } frame_t;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic [2:0] vld = '0;
    logic [8:0] dat = '0;
    logic [1:0] pm = '0;
    logic       two = 1'b0;
    logic       brk = 1'b0;
    logic [1:0] sel = '0;
    logic [2:0] rdy, line, done, fdone;
    logic [2:0] cnt0, cnt1, cnt2;
    logic       lineMux, doneMux, fdoneMux;

    frame_t sb[$];
    frame_t e;
    int     nChecks = 0, nFails = 0, cyc = 0, lastDone = -100;
    int     pulses, doneAt, n;
    bit     monEn = 1'b1, monBusy = 1'b0;

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    assign lineMux  = line[sel];
    assign doneMux  = done[sel];
    assign fdoneMux = fdone[sel];

    uart_tx_fifo #(.DATA_BITS(8), .OVERSAMPLE(16), .FIFO_DEPTH(4)) dut0 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .xmit_validH(vld[0]), .xmit_dataH(dat[7:0]),
        .xmit_readyH(rdy[0]), .parity_modeH(pm), .two_stopH(two), .break_reqH(brk),
        .uart_xmitH(line[0]), .xmit_doneH(done[0]), .frame_doneH(fdone[0]), .fifo_countH(cnt0));
    uart_tx_fifo #(.DATA_BITS(5), .OVERSAMPLE(4), .FIFO_DEPTH(4)) dut1 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .xmit_validH(vld[1]), .xmit_dataH(dat[4:0]),
        .xmit_readyH(rdy[1]), .parity_modeH(pm), .two_stopH(two), .break_reqH(brk),
        .uart_xmitH(line[1]), .xmit_doneH(done[1]), .frame_doneH(fdone[1]), .fifo_countH(cnt1));
    uart_tx_fifo #(.DATA_BITS(9), .OVERSAMPLE(16), .FIFO_DEPTH(4)) dut2 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .xmit_validH(vld[2]), .xmit_dataH(dat),
        .xmit_readyH(rdy[2]), .parity_modeH(pm), .two_stopH(two), .break_reqH(brk),
        .uart_xmitH(line[2]), .xmit_doneH(done[2]), .frame_doneH(fdone[2]), .fifo_countH(cnt2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected line level per cell: start, data LSB first, optional parity, stop(s)
    function automatic frame_t mk(input logic [8:0] w, input int nb, input logic [1:0] m,
                                  input bit ts, input int os, input bit b2b);
        frame_t f;
        logic   p  = 1'b0;
        bit     pe = (m == 2'b01) || (m == 2'b10);
        f.bits    = 16'hFFFF;
        f.bits[0] = 1'b0;
        for (int i = 0; i < nb; i++) begin
            f.bits[1+i] = w[i];
            p ^= w[i];
        end
        if (pe) f.bits[1+nb] = (m == 2'b01) ? ~p : p;
        f.cells = 1 + nb + int'(pe) + (ts ? 2 : 1);
        f.os    = os;
        f.b2b   = b2b;
        return f;
    endfunction

    task automatic waitDrain(input int maxc);
        int k = 0;
        do begin
            @(negedge sys_clk);
            k++;
        end while (!(sb.size() == 0 && !monBusy && doneMux === 1'b1) && k < maxc);
        chk("drain timeout", k < maxc, 1);
    endtask

    // Monitor: pops the expected frame when the line falls and checks every cell centre
    initial begin
        forever begin
            @(negedge sys_clk);
            if (fdoneMux === 1'b1) lastDone = cyc;
            if (monEn && !sys_rst && lineMux === 1'b0) begin
                monBusy = 1'b1;
                chk("frame expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    if (e.b2b) chk("idle gap", cyc - lastDone - 1, 0);
                    pulses = 0;
                    doneAt = -1;
                    for (int k = 0; k < e.cells * e.os; k++) begin
                        if (k > 0) @(negedge sys_clk);
                        if (k % e.os == e.os / 2) chk("cell level", lineMux, e.bits[k/e.os]);
                        if (fdoneMux === 1'b1) begin
                            pulses++;
                            doneAt   = k;
                            lastDone = cyc;
                        end
                    end
                    chk("frame_done pulses", pulses, 1);
                    chk("frame length", doneAt + 1, e.cells * e.os);
                end else begin
                    n = 0;
                    while (lineMux === 1'b0 && n < 4000) begin
                        @(negedge sys_clk);
                        n++;
                    end
                end
                monBusy = 1'b0;
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge sys_clk);
        chk("reset line", line[0], 1);
        chk("reset done", done[0], 1);
        chk("reset frame_done", fdone[0], 0);
        chk("reset count", cnt0, 0);
        chk("reset ready", rdy[0], 1);
        sys_rst = 1'b0;
        @(negedge sys_clk);

        // 8N1 frame with latency check
        dat = 9'h055; vld[0] = 1'b1;
        sb.push_back(mk(9'h055, 8, 2'b00, 1'b0, 16, 1'b0));
        @(negedge sys_clk);
        vld = '0;
        chk("count after push", cnt0, 1);
        chk("done after push", done[0], 0);
        @(negedge sys_clk);
        chk("latency line high", line[0], 1);
        @(negedge sys_clk);
        chk("latency line low", line[0], 0);
        waitDrain(400);
        chk("done after frame", done[0], 1);

        // Even parity, two stop bits, then odd parity
        pm = 2'b10; two = 1'b1;
        @(negedge sys_clk);
        dat = 9'h007; vld[0] = 1'b1;
        sb.push_back(mk(9'h007, 8, 2'b10, 1'b1, 16, 1'b0));
        @(negedge sys_clk);
        vld = '0;
        waitDrain(400);
        pm = 2'b01;
        @(negedge sys_clk);
        dat = 9'h007; vld[0] = 1'b1;
        sb.push_back(mk(9'h007, 8, 2'b01, 1'b1, 16, 1'b0));
        @(negedge sys_clk);
        vld = '0;
        waitDrain(400);

        // Back-to-back words until full
        pm = 2'b00; two = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge sys_clk);
            dat = 9'(i + 1); vld[0] = 1'b1;
            chk("ready while filling", rdy[0], 1);
            sb.push_back(mk(9'(i + 1), 8, 2'b00, 1'b0, 16, i > 0));
        end
        @(negedge sys_clk);
        dat = 9'h006;
        chk("ready when full", rdy[0], 0);
        chk("count when full", cnt0, 4);
        @(negedge sys_clk);
        chk("count after refused push", cnt0, 4);
        vld = '0;
        waitDrain(1500);

        // Mid-frame format changes and break request
        pm = 2'b10; two = 1'b1;
        @(negedge sys_clk);
        dat = 9'h0A5; vld[0] = 1'b1;
        sb.push_back(mk(9'h0A5, 8, 2'b10, 1'b1, 16, 1'b0));
        @(negedge sys_clk);
        dat = 9'h03C;
        sb.push_back(mk(9'h03C, 8, 2'b00, 1'b0, 16, 1'b1));
        @(negedge sys_clk);
        vld = '0;
        repeat (20) @(negedge sys_clk);
        pm = 2'b00; two = 1'b0; brk = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 1000) begin
            @(negedge sys_clk);
            n++;
        end
        chk("second frame started", n < 1000, 1);
        monEn = 1'b0;
        n = 0;
        while (monBusy && n < 1000) begin
            @(negedge sys_clk);
            n++;
        end
        repeat (5) @(negedge sys_clk);
        chk("break holds line", line[0], 0);
        chk("done during break", done[0], 0);
        dat = 9'h081; vld[0] = 1'b1;
        sb.push_back(mk(9'h081, 8, 2'b00, 1'b0, 16, 1'b0));
        @(negedge sys_clk);
        vld = '0;
        repeat (40) @(negedge sys_clk);
        chk("word held by break", cnt0, 1);
        chk("line low with word queued", line[0], 0);
        brk = 1'b0;
        @(negedge sys_clk);
        monEn = 1'b1;
        waitDrain(400);

        // Reset in the middle of a frame with words queued
        monEn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge sys_clk);
            dat = 9'(8'h11 * (i + 1)); vld[0] = 1'b1;
        end
        @(negedge sys_clk);
        vld = '0;
        repeat (40) @(negedge sys_clk);
        chk("queued before reset", cnt0, 3);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        chk("abort line", line[0], 1);
        chk("abort count", cnt0, 0);
        chk("abort done", done[0], 1);
        chk("abort frame_done", fdone[0], 0);
        pulses = 0;
        n = 0;
        repeat (200) begin
            @(negedge sys_clk);
            if (fdone[0] !== 1'b0) pulses++;
            if (line[0] !== 1'b1) n++;
        end
        chk("no frame_done after abort", pulses, 0);
        chk("line idle after abort", n, 0);
        monEn = 1'b1;

        // Width and ratio corners
        sel = 2'd1;
        @(negedge sys_clk);
        dat = 9'h015; vld[1] = 1'b1;
        sb.push_back(mk(9'h015, 5, 2'b00, 1'b0, 4, 1'b0));
        @(negedge sys_clk);
        vld = '0;
        waitDrain(200);
        sel = 2'd2;
        pm = 2'b01;
        @(negedge sys_clk);
        dat = 9'h1FF; vld[2] = 1'b1;
        sb.push_back(mk(9'h1FF, 9, 2'b01, 1'b0, 16, 1'b0));
        @(negedge sys_clk);
        vld = '0;
        waitDrain(400);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
